// File: rtl/axi_led_regs.sv
// axi_led_regs: AXI4-Lite register block (CTRL, PERIOD, STATUS, SCRATCH) driving the LED blinker.
// Write and read channels run as independent three-state FSMs; the board switch is 2-flop synchronized.
module axi_led_regs #(
    parameter int          ADDR_W     = 5,
    parameter logic [24:0] PERIOD_RST = 25'h1FFFFFF
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic              sw,
    output logic              blink_en,
    output logic              blink_force,
    output logic [24:0]       blink_period
);
    typedef enum logic [1:0] {W_IDLE, W_ACC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACC, R_DATA} r_state_t;
    w_state_t    r_wr_st, w_wr_nxt;
    r_state_t    r_rd_st, w_rd_nxt;
    logic [2:0]  r_waddr, r_raddr;
    logic [31:0] r_wdata, r_scratch, r_rdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_ctrl, r_bresp, r_rresp;
    logic [24:0] r_period, r_blink_period;
    logic        r_sync1, r_sync2, r_blink_en, r_blink_force;
    logic [31:0] w_old, w_merged, w_rd_val;
    logic [1:0]  w_bresp, w_rd_resp;
    logic        w_unused_addr;
    assign w_unused_addr = &{s_axi_awaddr, s_axi_araddr};
    always_comb begin
        w_wr_nxt = (r_wr_st == W_IDLE) ? ((s_axi_awvalid && s_axi_wvalid) ? W_ACC : W_IDLE) :
                   (r_wr_st == W_ACC)  ? W_RESP :
                   (s_axi_bready ? W_IDLE : W_RESP);
        w_rd_nxt = (r_rd_st == R_IDLE) ? (s_axi_arvalid ? R_ACC : R_IDLE) :
                   (r_rd_st == R_ACC)  ? R_DATA :
                   (s_axi_rready ? R_IDLE : R_DATA);
    end
    // Strobe merge against the current register contents; unused bits merge in as 0
    always_comb begin
        w_old = (r_waddr == 3'd0) ? {30'b0, r_ctrl} :
                (r_waddr == 3'd1) ? {7'b0, r_period} :
                (r_waddr == 3'd3) ? r_scratch : 32'b0;
        w_merged = w_old;
        for (int i = 0; i < 4; i++)
            w_merged[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : w_old[8*i +: 8];
        w_bresp = (r_waddr > 3'd3) ? 2'b11 :
                  (r_waddr == 3'd2) ? 2'b10 :
                  (r_waddr == 3'd1 && w_merged[24:0] == 25'b0) ? 2'b10 : 2'b00;
        w_rd_val = (r_raddr == 3'd0) ? {30'b0, r_ctrl} :
                   (r_raddr == 3'd1) ? {7'b0, r_period} :
                   (r_raddr == 3'd2) ? {31'b0, r_sync2} :
                   (r_raddr == 3'd3) ? r_scratch : 32'b0;
        w_rd_resp = (r_raddr > 3'd3) ? 2'b11 : 2'b00;
    end
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_wr_st        <= W_IDLE;
            r_rd_st        <= R_IDLE;
            r_waddr        <= '0;
            r_raddr        <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_ctrl         <= '0;
            r_period       <= PERIOD_RST;
            r_scratch      <= '0;
            r_bresp        <= '0;
            r_rdata        <= '0;
            r_rresp        <= '0;
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_blink_en     <= 1'b0;
            r_blink_force  <= 1'b0;
            r_blink_period <= PERIOD_RST;
        end else begin
            r_wr_st <= w_wr_nxt;
            r_rd_st <= w_rd_nxt;
            if (r_wr_st == W_IDLE && s_axi_awvalid && s_axi_wvalid) begin
                r_waddr <= s_axi_awaddr[4:2];
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (r_wr_st == W_ACC) begin
                r_bresp <= w_bresp;
                if (w_bresp == 2'b00 && r_waddr == 3'd0) r_ctrl <= w_merged[1:0];
                if (w_bresp == 2'b00 && r_waddr == 3'd1) r_period <= w_merged[24:0];
                if (w_bresp == 2'b00 && r_waddr == 3'd3) r_scratch <= w_merged;
            end
            if (r_rd_st == R_IDLE && s_axi_arvalid) r_raddr <= s_axi_araddr[4:2];
            if (r_rd_st == R_ACC) begin
                r_rdata <= w_rd_val;
                r_rresp <= w_rd_resp;
            end
            r_sync1        <= sw;
            r_sync2        <= r_sync1;
            r_blink_en     <= r_ctrl[0] & r_sync2;
            r_blink_force  <= r_ctrl[1];
            r_blink_period <= r_period;
        end
    end
    // Outputs are forced to their reset values for the whole time rst is high
    assign s_axi_awready = !rst && r_wr_st == W_ACC;
    assign s_axi_wready  = !rst && r_wr_st == W_ACC;
    assign s_axi_bvalid  = !rst && r_wr_st == W_RESP;
    assign s_axi_bresp   = rst ? 2'b00 : r_bresp;
    assign s_axi_arready = !rst && r_rd_st == R_ACC;
    assign s_axi_rvalid  = !rst && r_rd_st == R_DATA;
    assign s_axi_rdata   = rst ? 32'b0 : r_rdata;
    assign s_axi_rresp   = rst ? 2'b00 : r_rresp;
    assign blink_en      = !rst && r_blink_en;
    assign blink_force   = !rst && r_blink_force;
    assign blink_period  = rst ? PERIOD_RST : r_blink_period;
endmodule

// File: tb/tb_axi_led_regs.sv
// tb_axi_led_regs: table-driven AXI4-Lite transactions plus hand sequences for handshake,
// reset-abort, simultaneous read/write and switch-synchronizer corner cases.
module tb_axi_led_regs;
    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        sw = 1'b0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic        blink_en, blink_force;
    logic [24:0] blink_period;
    int          n_assert = 0;
    int          n_fail = 0;

    axi_led_regs dut (
        .sysclk(sysclk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .sw(sw),
        .blink_en(blink_en), .blink_force(blink_force), .blink_period(blink_period)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t v[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!s_axi_awready && n < 20);
        chk("awready_timeout", {31'b0, s_axi_awready}, 32'd1);
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin step(); n++; end
        chk("bvalid_timeout", {31'b0, s_axi_bvalid}, 32'd1);
        resp = s_axi_bresp;
        step();
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!s_axi_arready && n < 20);
        chk("arready_timeout", {31'b0, s_axi_arready}, 32'd1);
        step();
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin step(); n++; end
        chk("rvalid_timeout", {31'b0, s_axi_rvalid}, 32'd1);
        d = s_axi_rdata;
        resp = s_axi_rresp;
        step();
        s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int          n;
        v[0]  = '{0, 5'h00, 32'h0,        4'h0, 2'b00, 32'h0};
        v[1]  = '{0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h01FFFFFF};
        v[2]  = '{0, 5'h0C, 32'h0,        4'h0, 2'b00, 32'h0};
        v[3]  = '{1, 5'h04, 32'h000000FF, 4'h1, 2'b00, 32'h0};
        v[4]  = '{0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h01FFFFFF};
        v[5]  = '{1, 5'h04, 32'h0,        4'hF, 2'b10, 32'h0};
        v[6]  = '{0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h01FFFFFF};
        v[7]  = '{1, 5'h04, 32'h12345678, 4'h3, 2'b00, 32'h0};
        v[8]  = '{0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h01FF5678};
        v[9]  = '{1, 5'h04, 32'hAB000000, 4'h8, 2'b00, 32'h0};
        v[10] = '{0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h01FF5678};
        v[11] = '{1, 5'h0C, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        v[12] = '{0, 5'h0C, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        v[13] = '{1, 5'h0C, 32'h00000011, 4'h1, 2'b00, 32'h0};
        v[14] = '{0, 5'h0C, 32'h0,        4'h0, 2'b00, 32'hDEADBE11};
        v[15] = '{1, 5'h08, 32'h00000001, 4'hF, 2'b10, 32'h0};
        v[16] = '{0, 5'h14, 32'h0,        4'h0, 2'b11, 32'h0};
        v[17] = '{1, 5'h1C, 32'h00000005, 4'hF, 2'b11, 32'h0};
        v[18] = '{0, 5'h0D, 32'h0,        4'h0, 2'b00, 32'hDEADBE11};
        v[19] = '{1, 5'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
        v[20] = '{0, 5'h00, 32'h0,        4'h0, 2'b00, 32'h3};
        v[21] = '{0, 5'h08, 32'h0,        4'h0, 2'b00, 32'h0};
        v[22] = '{1, 5'h00, 32'h0,        4'hF, 2'b00, 32'h0};

        // Reset state
        repeat (3) step();
        chk("rst_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
        chk("rst_valid", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        chk("rst_resp_data", {s_axi_rdata[27:0], s_axi_bresp, s_axi_rresp}, 32'h0);
        chk("rst_blink", {30'b0, blink_en, blink_force}, 32'h0);
        chk("rst_period", {7'b0, blink_period}, 32'h01FFFFFF);
        rst = 1'b0;
        step();

        for (int i = 0; i < 23; i++) begin
            if (v[i].wr) begin
                do_write(v[i].addr, v[i].data, v[i].strb, resp);
                chk($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, v[i].resp});
            end else begin
                do_read(v[i].addr, d, resp);
                chk($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, v[i].resp});
                chk($sformatf("vec%0d_rdata", i), d, v[i].rdata);
            end
        end
        step();
        chk("blink_period_out", {7'b0, blink_period}, 32'h01FF5678);

        // Switch synchronizer and blink_en gating
        sw = 1'b1;
        repeat (4) step();
        do_write(5'h00, 32'h1, 4'hF, resp);
        chk("ctrl_en_bresp", {30'b0, resp}, 32'h0);
        n = 0;
        while (!blink_en && n < 3) begin step(); n++; end
        chk("blink_en_on", {31'b0, blink_en}, 32'h1);
        chk("blink_force_off", {31'b0, blink_force}, 32'h0);
        do_read(5'h08, d, resp);
        chk("status_sw1", d, 32'h1);
        sw = 1'b0;
        step();
        step();
        chk("blink_en_hold", {31'b0, blink_en}, 32'h1);
        step();
        chk("blink_en_off", {31'b0, blink_en}, 32'h0);
        do_write(5'h00, 32'h2, 4'h1, resp);
        step();
        chk("blink_force_on", {31'b0, blink_force}, 32'h1);

        // AW ahead of W, then a stalled response
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'h00000055; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("aw_only_no_ready", {30'b0, s_axi_awready, s_axi_wready}, 32'h0);
        end
        s_axi_wvalid = 1'b1;
        step();
        chk("aw_w_ready", {30'b0, s_axi_awready, s_axi_wready}, 32'h3);
        chk("bvalid_not_yet", {31'b0, s_axi_bvalid}, 32'h0);
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("bvalid_latency", {31'b0, s_axi_bvalid}, 32'h1);
        chk("awready_one_cycle", {31'b0, s_axi_awready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bvalid_stall", {29'b0, s_axi_bvalid, s_axi_bresp}, 32'h4);
        end
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        chk("bvalid_drop", {31'b0, s_axi_bvalid}, 32'h0);
        do_read(5'h0C, d, resp);
        chk("scratch_55", d, 32'h00000055);

        // Simultaneous read and write to SCRATCH
        do_write(5'h0C, 32'h1, 4'hF, resp);
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF;
        s_axi_araddr = 5'h0C;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        step();
        chk("sim_ready", {30'b0, s_axi_awready, s_axi_arready}, 32'h3);
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        chk("sim_valid", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'h3);
        chk("sim_old_value", s_axi_rdata, 32'h1);
        step();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        do_read(5'h0C, d, resp);
        chk("sim_new_value", d, 32'h2);

        // Reset while a response is pending
        s_axi_awaddr = 5'h04; s_axi_wdata = 32'h00000077; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        step();
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("pre_rst_bvalid", {31'b0, s_axi_bvalid}, 32'h1);
        rst = 1'b1;
        step();
        chk("rst_bvalid_drop", {31'b0, s_axi_bvalid}, 32'h0);
        rst = 1'b0;
        s_axi_bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_late_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
        end
        s_axi_bready = 1'b0;
        chk("rst_blink_period", {7'b0, blink_period}, 32'h01FFFFFF);
        do_read(5'h04, d, resp);
        chk("rst_period_reg", d, 32'h01FFFFFF);
        do_read(5'h00, d, resp);
        chk("rst_ctrl_reg", d, 32'h0);
        do_read(5'h0C, d, resp);
        chk("rst_scratch_reg", d, 32'h0);

        // Reset while the write is being accepted: no commit, no response
        s_axi_awaddr = 5'h04; s_axi_wdata = 32'h00000033; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        step();
        chk("abort_in_acc", {31'b0, s_axi_awready}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
        end
        s_axi_bready = 1'b0;
        do_read(5'h04, d, resp);
        chk("abort_period", d, 32'h01FFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
